// File: rtl/pipe_shifter_pkg.sv
// Shared opcode encoding and the mapping from mux level to pipeline stage
// for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_ROR = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  function automatic int stage_of(input int level, input int stages, input int levels);
    return (level * stages) / levels;
  endfunction

  // Highest mux level that lands in the given stage; its output feeds that stage's register.
  function automatic int last_level(input int stage, input int stages, input int levels);
    int last;
    last = 0;
    for (int k = 0; k < levels; k++) begin
      if (stage_of(k, stages, levels) == stage) begin
        last = k;
      end else begin
        last = last;
      end
    end
    return last;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the barrel shifter: conditionally shifts or
// rotates by 2**LEVEL, filling with zero or the carried sign bit.
module shift_level
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL      = 0
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  en_i,
  input  logic [1:0]            op_i,
  input  logic                  sign_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int SH = 1 << LEVEL;

  // Single shift/rotate step selected by the opcode
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (shift_op_e'(op_i))
        OP_SLL:  data_o = {data_i[DATA_WIDTH-SH-1:0], {SH{1'b0}}};
        OP_ROR:  data_o = {data_i[SH-1:0], data_i[DATA_WIDTH-1:SH]};
        OP_SRL:  data_o = {{SH{1'b0}}, data_i[DATA_WIDTH-1:SH]};
        OP_SRA:  data_o = {{SH{sign_i}}, data_i[DATA_WIDTH-1:SH]};
        default: data_o = data_i;
      endcase
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined shifter/rotator with valid/ready handshakes on both sides,
// a sideband tag, synchronous flush and log2(DATA_WIDTH) mux levels spread over STAGES registers.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_a,
  input  logic [$clog2(DATA_WIDTH)-1:0] in_b,
  input  logic [1:0]                    in_op,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_result,
  output logic [TAG_WIDTH-1:0]          out_tag
);

  localparam int LEVELS = $clog2(DATA_WIDTH);

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];
  logic [LEVELS-1:0]     amt_q  [STAGES];
  logic [LEVELS-1:0]     amt_d  [STAGES];
  logic [1:0]            op_q   [STAGES];
  logic [1:0]            op_d   [STAGES];
  logic                  sign_q [STAGES];
  logic                  sign_d [STAGES];
  logic [TAG_WIDTH-1:0]  tag_q  [STAGES];
  logic [TAG_WIDTH-1:0]  tag_d  [STAGES];
  logic                  ready_q;

  logic [STAGES-1:0]     adv_s;
  logic [STAGES-1:0]     src_valid;
  logic [DATA_WIDTH-1:0] src_data [STAGES];
  logic [LEVELS-1:0]     src_amt  [STAGES];
  logic [1:0]            src_op   [STAGES];
  logic                  src_sign [STAGES];
  logic [TAG_WIDTH-1:0]  src_tag  [STAGES];
  logic [DATA_WIDTH-1:0] stg_res  [STAGES];
  logic                  accept_s;
  logic                  unused_s;

  // A stage moves when it or any later stage is empty, or the consumer takes the result.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    assign adv_s[s] = out_ready || !(&valid_q[STAGES-1:s]);
    if (s == 0) begin : g_head
      assign src_valid[0] = accept_s;
      assign src_data[0]  = in_a;
      assign src_amt[0]   = in_b;
      assign src_op[0]    = in_op;
      assign src_sign[0]  = in_a[DATA_WIDTH-1];
      assign src_tag[0]   = in_tag;
    end else begin : g_body
      assign src_valid[s] = valid_q[s-1];
      assign src_data[s]  = data_q[s-1];
      assign src_amt[s]   = amt_q[s-1];
      assign src_op[s]    = op_q[s-1];
      assign src_sign[s]  = sign_q[s-1];
      assign src_tag[s]   = tag_q[s-1];
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int STG = stage_of(k, STAGES, LEVELS);
    logic [DATA_WIDTH-1:0] l_in;
    logic [DATA_WIDTH-1:0] l_out;
    if (k == 0) begin : g_first
      assign l_in = src_data[STG];
    end else if (stage_of(k - 1, STAGES, LEVELS) != STG) begin : g_cross
      assign l_in = src_data[STG];
    end else begin : g_chain
      assign l_in = g_lvl[k-1].l_out;
    end
    shift_level #(
      .DATA_WIDTH(DATA_WIDTH),
      .LEVEL     (k)
    ) u_level (
      .data_i(l_in),
      .en_i  (src_amt[STG][k]),
      .op_i  (src_op[STG]),
      .sign_i(src_sign[STG]),
      .data_o(l_out)
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_res
    assign stg_res[s] = g_lvl[last_level(s, STAGES, LEVELS)].l_out;
  end

  // ready_q keeps in_ready low throughout reset and for the first cycle after release.
  assign in_ready   = ready_q && !flush && (!valid_q[0] || adv_s[0]);
  assign accept_s   = in_valid && in_ready;
  assign out_valid  = valid_q[STAGES-1];
  assign out_result = data_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];

  // Next state of every pipeline register: load when advancing, otherwise hold
  always_comb begin
    valid_d = valid_q;
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = data_q[s];
      amt_d[s]  = amt_q[s];
      op_d[s]   = op_q[s];
      sign_d[s] = sign_q[s];
      tag_d[s]  = tag_q[s];
      if (adv_s[s]) begin
        valid_d[s] = src_valid[s];
        data_d[s]  = stg_res[s];
        amt_d[s]   = src_amt[s];
        op_d[s]    = src_op[s];
        sign_d[s]  = src_sign[s];
        tag_d[s]   = src_tag[s];
      end else begin
        valid_d[s] = valid_q[s];
      end
      if (flush) begin
        valid_d[s] = 1'b0;
      end else begin
        valid_d[s] = valid_d[s];
      end
    end
  end

  // Sideband of the final stage has no further consumer
  always_comb begin
    unused_s = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      unused_s = unused_s ^ (^{amt_q[s], op_q[s], sign_q[s]});
    end
  end

  // Pipeline stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        amt_q[s]  <= '0;
        op_q[s]   <= 2'b00;
        sign_q[s] <= 1'b0;
        tag_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
        amt_q[s]  <= amt_d[s];
        op_q[s]   <= op_d[s];
        sign_q[s] <= sign_d[s];
        tag_q[s]  <= tag_d[s];
      end
    end
  end

  // Input-side enable, set on the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed self-checking bench for pipe_shifter at DATA_WIDTH=32, STAGES=2.
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_b;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  pipe_shifter #(.DATA_WIDTH(32), .STAGES(2), .TAG_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [4:0] b,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] b, input logic [3:0] tag, input logic [31:0] exp);
    drive(op, a, b, tag);
    #1;
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    step();
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_result"}, 64'(out_result), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    step();
    chk({name, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 5'd0; in_op = 2'b00;
    in_tag = 4'd0; flush = 1'b0; out_ready = 1'b1;

    // reset state
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", 64'(in_ready), 64'd0);
    step();
    chk("rel_in_ready_post", 64'(in_ready), 64'd1);

    // single operations
    run_one("sra_neg4",  2'b11, 32'h8000_0000, 5'd4,  4'd1, 32'hF800_0000);
    run_one("srl_4",     2'b10, 32'h8000_0000, 5'd4,  4'd2, 32'h0800_0000);
    run_one("ror_1",     2'b01, 32'h0000_0001, 5'd1,  4'd3, 32'h8000_0000);
    run_one("sll_31",    2'b00, 32'h0000_0001, 5'd31, 4'd4, 32'h8000_0000);
    run_one("sll_b0",    2'b00, 32'h1234_5678, 5'd0,  4'd5, 32'h1234_5678);
    run_one("ror_b0",    2'b01, 32'h1234_5678, 5'd0,  4'd6, 32'h1234_5678);
    run_one("srl_b0",    2'b10, 32'h1234_5678, 5'd0,  4'd7, 32'h1234_5678);
    run_one("sra_b0",    2'b11, 32'h1234_5678, 5'd0,  4'd8, 32'h1234_5678);
    run_one("ror_8",     2'b01, 32'h1234_5678, 5'd8,  4'd9, 32'h7812_3456);
    run_one("sra_pos4",  2'b11, 32'h7FFF_FFF0, 5'd4,  4'd10, 32'h07FF_FFFF);
    run_one("sra_31",    2'b11, 32'h8000_0000, 5'd31, 4'd11, 32'hFFFF_FFFF);
    run_one("sll_ones31",2'b00, 32'hFFFF_FFFF, 5'd31, 4'd12, 32'h8000_0000);
    run_one("srl_31",    2'b10, 32'hFFFF_FFFF, 5'd31, 4'd13, 32'h0000_0001);

    // back-to-back stream: op j accepted in cycle j, seen at output in cycle j+2
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        drive(2'b00, 32'(c), 5'd1, 4'(c));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) chk("b2b_ready", 64'(in_ready), 64'd1);
      chk("b2b_valid", 64'(out_valid), (c >= 2) ? 64'd1 : 64'd0);
      if (c >= 2) begin
        chk("b2b_tag", 64'(out_tag), 64'(c - 2));
        chk("b2b_result", 64'(out_result), 64'((c - 2) * 2));
      end
      step();
    end
    chk("b2b_drain", 64'(out_valid), 64'd0);

    // backpressure: out_ready low for 5 cycles with input offered throughout
    out_ready = 1'b0;
    drive(2'b10, 32'h0000_0100, 5'd4, 4'd8);
    #1;
    chk("bp_ready_a", 64'(in_ready), 64'd1);
    step();
    drive(2'b10, 32'h0000_0200, 5'd4, 4'd9);
    #1;
    chk("bp_ready_b", 64'(in_ready), 64'd1);
    step();
    drive(2'b10, 32'h0000_0300, 5'd4, 4'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_result", 64'(out_result), 64'h10);
      chk("bp_hold_tag", 64'(out_tag), 64'd8);
      step();
    end
    chk("bp_last_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_result", 64'(out_result), 64'h10);
    step();
    in_valid = 1'b0;
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_result", 64'(out_result), 64'h20);
    chk("bp_b_tag", 64'(out_tag), 64'd9);
    step();
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    chk("bp_c_result", 64'(out_result), 64'h30);
    chk("bp_c_tag", 64'(out_tag), 64'd10);
    step();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // flush with two ops in flight and a third offered
    out_ready = 1'b0;
    drive(2'b00, 32'd11, 5'd0, 4'd11);
    step();
    drive(2'b00, 32'd12, 5'd0, 4'd12);
    step();
    drive(2'b00, 32'd13, 5'd0, 4'd13);
    flush = 1'b1;
    #1;
    chk("fl_ready_low", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_cleared", 64'(out_valid), 64'd0);
    chk("fl_ready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fl_no_stale", 64'(out_valid), 64'd0);
    step();
    chk("fl_next_valid", 64'(out_valid), 64'd1);
    chk("fl_next_result", 64'(out_result), 64'd13);
    chk("fl_next_tag", 64'(out_tag), 64'd13);
    step();
    chk("fl_drain", 64'(out_valid), 64'd0);

    // reset pulse mid-stream
    drive(2'b01, 32'h0000_00AA, 5'd4, 4'd1);
    step();
    drive(2'b01, 32'h0000_00BB, 5'd4, 4'd2);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_result", 64'(out_result), 64'd0);
    chk("mrst_out_tag", 64'(out_tag), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mrst_ready_pre", 64'(in_ready), 64'd0);
    step();
    chk("mrst_ready_post", 64'(in_ready), 64'd1);
    chk("mrst_no_stale1", 64'(out_valid), 64'd0);
    step();
    chk("mrst_no_stale2", 64'(out_valid), 64'd0);
    run_one("mrst_after", 2'b10, 32'hF000_0000, 5'd28, 4'd15, 32'h0000_000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
